// File: rtl/uart_hex_display_ctrl_if.sv
// UART byte-stream bundle between receiver/transmitter and the display ctrl.
// RX byte + valid in, TX busy in, TX request + byte out.
interface uart_hex_display_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_TX_Active;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;

  modport master (
    output i_RX_DV,
    output i_RX_Byte,
    output i_TX_Active,
    input  o_TX_DV,
    input  o_TX_Byte
  );

  modport slave (
    input  i_RX_DV,
    input  i_RX_Byte,
    input  i_TX_Active,
    output o_TX_DV,
    output o_TX_Byte
  );
endinterface

// File: rtl/uart_hex_display_ctrl.sv
// UART-to-hex display: shifts received bytes into N hex digits, drives
// 7-seg glyphs, flags bad ASCII, echoes bytes through a 1-entry buffer.
module uart_hex_display_ctrl #(
  parameter int NUM_DIGITS     = 2,
  parameter int ASCII_MODE     = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int ECHO_EN        = 1
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  uart_hex_display_ctrl_if.slave    uart,
  output logic [4*NUM_DIGITS-1:0]   o_Digits,
  output logic [7*NUM_DIGITS-1:0]   o_Segments,
  output logic                      o_Error,
  output logic                      o_Echo_Drop
);

  localparam int W = 4*NUM_DIGITS;
  localparam int S = 7*NUM_DIGITS;

  localparam logic [6:0] SEG_ZERO =
    (SEG_ACTIVE_LOW != 0) ? 7'h40 : 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_GUARD
  } echo_st_e;

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [7:0]   b;
  logic         rx_dv;
  logic         is_dig;
  logic         is_up;
  logic         is_lo;
  logic         is_bs;
  logic         is_esc;
  logic [3:0]   nib;
  logic [W-1:0] d_nxt;
  logic         bad;

  logic [W-1:0] d_q;
  logic         err_q;
  logic [S-1:0] seg_q;

  assign b      = uart.i_RX_Byte;
  assign rx_dv  = uart.i_RX_DV;
  assign is_dig = (b >= 8'h30) && (b <= 8'h39);
  assign is_up  = (b >= 8'h41) && (b <= 8'h46);
  assign is_lo  = (b >= 8'h61) && (b <= 8'h66);
  assign is_bs  = (b == 8'h08);
  assign is_esc = (b == 8'h1B);
  assign nib    = is_dig ? b[3:0]
                         : b[3:0] + 4'd9;

  always_comb begin
    d_nxt = d_q;
    bad   = 1'b0;
    if (ASCII_MODE == 0) begin
      d_nxt = (d_q << 8) | W'(b);
    end else begin
      unique case (1'b1)
        is_dig,
        is_up,
        is_lo:  d_nxt = (d_q << 4) | W'(nib);
        is_bs:  d_nxt = d_q >> 4;
        is_esc: d_nxt = '0;
        default: bad = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      d_q   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (rx_dv) begin
        d_q   <= d_nxt;
        err_q <= bad;
      end
    end
  end

  // Glyph stage: one register behind the digit value.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int k = 0; k < NUM_DIGITS; k++)
        seg_q[7*k +: 7] <= SEG_ZERO;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++)
        seg_q[7*k +: 7] <= (SEG_ACTIVE_LOW != 0)
                           ? ~hex7(d_q[4*k +: 4])
                           :  hex7(d_q[4*k +: 4]);
    end
  end

  echo_st_e   st_q;
  logic [7:0] buf_q;
  logic       full_q;
  logic       gcnt_q;
  logic       tx_dv_q;
  logic [7:0] tx_byte_q;
  logic       drop_q;

  logic       rx_echo;
  logic       leave;
  logic       take;

  assign rx_echo = rx_dv && (ECHO_EN != 0);
  // Leaving WAIT hands B to the transmitter on this edge, so a byte
  // arriving in the same cycle can refill the buffer.
  assign leave   = (st_q == S_WAIT) && !uart.i_TX_Active;
  assign take    = rx_echo && (!full_q || leave);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      st_q      <= S_IDLE;
      buf_q     <= 8'h00;
      full_q    <= 1'b0;
      gcnt_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      drop_q    <= 1'b0;
    end else begin
      tx_dv_q <= 1'b0;
      drop_q  <= rx_echo && !take;
      if (leave)
        full_q <= 1'b0;
      if (take) begin
        buf_q  <= b;
        full_q <= 1'b1;
      end
      case (st_q)
        S_IDLE: begin
          if (take)
            st_q <= S_WAIT;
        end
        S_WAIT: begin
          if (leave) begin
            st_q      <= S_ISSUE;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= buf_q;
          end
        end
        S_ISSUE: begin
          st_q   <= S_GUARD;
          gcnt_q <= 1'b0;
        end
        S_GUARD: begin
          // Busy is ignored here: the transmitter raises it a cycle late.
          if (gcnt_q)
            st_q <= (full_q || take) ? S_WAIT : S_IDLE;
          else
            gcnt_q <= 1'b1;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign o_Digits       = d_q;
  assign o_Segments     = seg_q;
  assign o_Error        = err_q;
  assign o_Echo_Drop    = drop_q;
  assign uart.o_TX_DV   = tx_dv_q;
  assign uart.o_TX_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_hex_display_ctrl.sv
// Directed bench: ASCII N=4 active-low echo DUT and raw N=2 active-high
// no-echo DUT; expected values are hand-computed constants.
module tb_uart_hex_display_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_hex_display_ctrl_if ua();
  uart_hex_display_ctrl_if ub();

  logic [15:0] a_dig;
  logic [27:0] a_seg;
  logic        a_err;
  logic        a_drop;
  logic [7:0]  b_dig;
  logic [13:0] b_seg;
  logic        b_err;
  logic        b_drop;

  uart_hex_display_ctrl #(
    .NUM_DIGITS(4), .ASCII_MODE(1),
    .SEG_ACTIVE_LOW(1), .ECHO_EN(1)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .uart(ua.slave),
    .o_Digits(a_dig), .o_Segments(a_seg),
    .o_Error(a_err), .o_Echo_Drop(a_drop)
  );

  uart_hex_display_ctrl #(
    .NUM_DIGITS(2), .ASCII_MODE(0),
    .SEG_ACTIVE_LOW(0), .ECHO_EN(0)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .uart(ub.slave),
    .o_Digits(b_dig), .o_Segments(b_seg),
    .o_Error(b_err), .o_Echo_Drop(b_drop)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int a_tx_n = 0;
  int a_drop_n = 0;
  int a_err_n = 0;
  int b_tx_n = 0;
  int b_drop_n = 0;
  int b_err_n = 0;
  logic [7:0] a_txq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (ua.o_TX_DV) begin
        a_tx_n++;
        a_txq.push_back(ua.o_TX_Byte);
      end
      if (a_drop) a_drop_n++;
      if (a_err)  a_err_n++;
      if (ub.o_TX_DV) b_tx_n++;
      if (b_drop) b_drop_n++;
      if (b_err)  b_err_n++;
    end
  end

  task automatic send_a(input logic [7:0] v, input int gap);
    @(negedge clk);
    ua.i_RX_DV   = 1'b1;
    ua.i_RX_Byte = v;
    @(negedge clk);
    ua.i_RX_DV   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] v);
    @(negedge clk);
    ub.i_RX_DV   = 1'b1;
    ub.i_RX_Byte = v;
    @(negedge clk);
    ub.i_RX_DV   = 1'b0;
  endtask

  localparam logic [27:0] A_SEG_RST = {4{7'h40}};
  localparam logic [13:0] B_SEG_RST = {2{7'h3F}};

  logic [7:0] exp_q [5];
  logic [7:0] got_b;
  int tx0;
  int dr0;

  initial begin
    ua.i_RX_DV = 1'b0; ua.i_RX_Byte = 8'h00; ua.i_TX_Active = 1'b0;
    ub.i_RX_DV = 1'b0; ub.i_RX_Byte = 8'h00; ub.i_TX_Active = 1'b0;
    exp_q = '{8'h31, 8'h61, 8'h46, 8'h33, 8'h37};

    repeat (2) @(negedge clk);
    check("rst_dig",   a_dig, 16'h0000);
    check("rst_seg",   a_seg, A_SEG_RST);
    check("rst_txdv",  ua.o_TX_DV, 1'b0);
    check("rst_txb",   ua.o_TX_Byte, 8'h00);
    check("rst_err",   a_err, 1'b0);
    check("rst_drop",  a_drop, 1'b0);
    check("rst_bdig",  b_dig, 8'h00);
    check("rst_bseg",  b_seg, B_SEG_RST);
    rst_n = 1'b1;
    @(negedge clk);

    // pending echo, then async reset mid-cycle
    ua.i_TX_Active = 1'b1;
    send_a(8'h35, 0);
    check("pre_rst_dig", a_dig, 16'h0005);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dig",  a_dig, 16'h0000);
    check("arst_seg",  a_seg, A_SEG_RST);
    check("arst_txdv", ua.o_TX_DV, 1'b0);
    #1 rst_n = 1'b1;
    ua.i_TX_Active = 1'b0;
    repeat (8) @(negedge clk);
    check("arst_no_echo", a_tx_n, 0);

    // ASCII entry
    a_txq.delete();
    tx0 = a_tx_n;
    send_a(8'h31, 6);
    send_a(8'h61, 6);
    send_a(8'h46, 6);
    send_a(8'h33, 6);
    send_a(8'h37, 0);
    check("dig_AF37",  a_dig, 16'hAF37);
    check("seg_lat1",  a_seg[6:0], 7'h30);
    @(negedge clk);
    check("seg_lat2",  a_seg[6:0], 7'h78);
    check("seg_all",   a_seg, {7'h08, 7'h0E, 7'h30, 7'h78});
    repeat (6) @(negedge clk);
    check("echo_cnt",  a_tx_n - tx0, 5);
    for (int i = 0; i < 5; i++) begin
      got_b = (i < a_txq.size()) ? a_txq[i] : 8'hxx;
      check($sformatf("echo_%0d", i), got_b, exp_q[i]);
    end
    check("no_drop_gaps", a_drop_n, 0);

    // edit commands
    send_a(8'h08, 0);
    check("bs",        a_dig, 16'h0AF3);
    repeat (6) @(negedge clk);
    send_a(8'h7A, 0);
    check("err_pulse", a_err, 1'b1);
    check("err_keep",  a_dig, 16'h0AF3);
    @(negedge clk);
    check("err_end",   a_err, 1'b0);
    repeat (6) @(negedge clk);
    send_a(8'h1B, 0);
    check("esc",       a_dig, 16'h0000);
    @(negedge clk);
    check("esc_seg",   a_seg, A_SEG_RST);
    repeat (6) @(negedge clk);

    // echo flow control
    tx0 = a_tx_n;
    dr0 = a_drop_n;
    ua.i_TX_Active = 1'b1;
    send_a(8'h41, 2);
    send_a(8'h42, 2);
    check("fc_drop",   a_drop_n - dr0, 1);
    check("fc_hold",   a_tx_n - tx0, 0);
    check("fc_dig",    a_dig, 16'h00AB);
    ua.i_TX_Active = 1'b0;
    repeat (6) @(negedge clk);
    check("fc_tx",     a_tx_n - tx0, 1);
    check("fc_byte",   ua.o_TX_Byte, 8'h41);

    // back-to-back burst
    send_a(8'h1B, 8);
    a_txq.delete();
    tx0 = a_tx_n;
    dr0 = a_drop_n;
    @(negedge clk);
    ua.i_RX_DV = 1'b1; ua.i_RX_Byte = 8'h31;
    @(negedge clk);
    ua.i_RX_Byte = 8'h32;
    @(negedge clk);
    ua.i_RX_Byte = 8'h33;
    @(negedge clk);
    ua.i_RX_DV = 1'b0;
    check("b2b_dig",   a_dig, 16'h0123);
    repeat (12) @(negedge clk);
    check("b2b_txn",   a_tx_n - tx0, 2);
    got_b = (a_txq.size() > 0) ? a_txq[0] : 8'hxx;
    check("b2b_tx0",   got_b, 8'h31);
    got_b = (a_txq.size() > 1) ? a_txq[1] : 8'hxx;
    check("b2b_tx1",   got_b, 8'h32);
    check("b2b_drop",  a_drop_n - dr0, 1);

    // raw mode
    send_b(8'h5C);
    check("raw_dig1",  b_dig, 8'h5C);
    @(negedge clk);
    check("raw_seg1",  b_seg, {7'h6D, 7'h39});
    send_b(8'hE1);
    check("raw_dig2",  b_dig, 8'hE1);
    @(negedge clk);
    check("raw_seg2",  b_seg, {7'h79, 7'h06});
    repeat (4) @(negedge clk);
    check("raw_no_err", b_err_n, 0);
    check("raw_no_tx",  b_tx_n, 0);
    check("raw_no_drop", b_drop_n, 0);
    check("a_err_total", a_err_n, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_hex_display_ctrl.md
Name: uart_hex_display_ctrl

Overview:
Parametrised UART-to-hex-display controller. It consumes the received-byte stream (byte plus one-cycle data-valid) from the UART receiver and maintains an N-digit hex value in a shift register. It drives N seven-segment digits and echoes every received byte back to the UART transmitter through a one-entry buffered handshake. It generalises the fixed two-digit raw-byte display: configurable digit count, ASCII hex parsing with edit commands, selectable segment polarity, and a flow-controlled echo path.

Parameters:
NUM_DIGITS, 2, number of displayed hex digits; legal 2..8; must be even when ASCII_MODE=0.
ASCII_MODE, 1, 1 = parse ASCII hex characters; 0 = raw mode, each byte shifts in two nibbles.
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0).
ECHO_EN, 1, 1 = echo received bytes to the transmitter; 0 = o_TX_DV held 0.

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_RX_DV  in  1  one-cycle pulse; i_RX_Byte valid
i_RX_Byte  in  8  received byte
i_TX_Active  in  1  transmitter busy
o_TX_DV  out  1  one-cycle request to transmitter
o_TX_Byte  out  8  byte to transmit; valid with o_TX_DV
o_Digits  out  4*NUM_DIGITS  current hex value; digit 0 in [3:0], rightmost
o_Segments  out  7*NUM_DIGITS  per digit {G,F,E,D,C,B,A}; digit k in [7k+6:7k]
o_Error  out  1  one-cycle pulse on an unrecognised ASCII byte
o_Echo_Drop  out  1  one-cycle pulse when an echo is discarded

Behaviour:
- Reset is asynchronous on i_Rst_L low; all state clears immediately. Reset mid-transfer abandons any pending echo.
- Reset values:
  - o_Digits = 0.
  - o_Segments = "0" glyph on every digit: 7'b0111111 per digit, or 7'b1000000 when SEG_ACTIVE_LOW.
  - o_TX_DV, o_Error, o_Echo_Drop = 0.
  - o_TX_Byte = 8'h00.
- Digit register D (ASCII_MODE=1), applied in the cycle after i_RX_DV:
  - '0'-'9', 'A'-'F', 'a'-'f': D <= {D[4N-5:0], nibble}; the top digit is discarded.
  - 0x08 (backspace): D <= {4'h0, D[4N-1:4]}.
  - 0x1B (ESC): D <= 0.
  - Any other byte: D unchanged; o_Error pulses one cycle.
- Digit register D (ASCII_MODE=0): D <= {D[4N-9:0], i_RX_Byte}; o_Error is never asserted.
- Latency:
  - o_Digits updates 1 cycle after i_RX_DV.
  - o_Segments is registered and updates 2 cycles after i_RX_DV.
  - Back-to-back i_RX_DV on consecutive cycles is processed fully; no bytes are lost to the display.
- Decoder: standard hex glyphs 0-F with lowercase b and d. The polarity inversion is applied in the registered stage.
- Echo FSM, states IDLE, WAIT, ISSUE, GUARD:
  - IDLE: on i_RX_DV (ECHO_EN=1), capture the byte into buffer B and go to WAIT.
  - WAIT: while i_TX_Active=1, stay. When it is 0, go to ISSUE.
  - ISSUE: o_TX_DV=1 and o_TX_Byte=B for exactly one cycle, then go to GUARD.
  - GUARD: 2 cycles during which i_TX_Active is ignored, covering the transmitter's one-cycle busy latency. Then go to WAIT if the buffer is full, else IDLE.
  - Buffer is full from capture until the ISSUE cycle.
  - i_RX_DV arriving in ISSUE or GUARD is captured, since the buffer was freed by ISSUE.
  - i_RX_DV arriving in WAIT (buffer full) is not echoed: o_Echo_Drop pulses 1 cycle, B is kept. The display still updates.
- o_TX_Byte holds its last value outside ISSUE.
- Error, ESC and backspace bytes are echoed like any other byte.

Test Plan:
- Reset: assert i_Rst_L=0 mid-frame -> outputs immediately at reset values; N=4, active-low, o_Segments = {4{7'b1000000}}.
- ASCII entry, N=4: send "1","a","F","3","7" with gaps -> o_Digits = 16'hAF37; segments for digit 0 show "7" exactly 2 cycles after the last DV.
- Edit commands: from 16'hAF37 send 0x08 -> 16'h0AF3; send 0x1B -> 16'h0000; send 'z' -> o_Error pulses 1 cycle, value unchanged.
- Raw mode, ASCII_MODE=0, N=2: send 0x5C -> o_Digits = 8'h5C; then send 0xE1 -> 8'hE1; o_Error never asserts.
- Echo flow control: hold i_TX_Active=1 and send 0x41 then 0x42 -> 0x42 gives an o_Echo_Drop pulse. Release busy -> a single o_TX_DV with 0x41.
- Back-to-back stress: DV on 3 consecutive cycles ("1","2","3"), TX idle -> display reads ..123; echoes 0x31 and 0x32 are issued in order; 0x33 is dropped only if it arrives while the buffer is full.
